rgb2raw_mosaic: RTL and testbench



---
 rtl/rgb2raw_pkg.sv | 40 ++++
 rtl/rgb2raw_line_ram.sv | 41 ++++
 rtl/rgb2raw_mosaic.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_rgb2raw_mosaic.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb2raw_pkg.sv
// -----------------------------------------------------------------------------
// rgb2raw_pkg
// Shared types and helpers for the RGB -> Bayer RAW re-mosaic block.
//   - RGB2RAW_DW : default bits per colour component
//   - CNT_W      : width of the raw column/row counters
//   - state_e    : row FSM states (even row from input, odd row from line RAM)
//   - bayer_e    : GRBG colour code of a raw sample position
//   - bayer_color: maps row/column LSBs to the GRBG colour code
// -----------------------------------------------------------------------------
package rgb2raw_pkg;

    localparam int RGB2RAW_DW = 10;
    localparam int CNT_W      = 11;

    typedef enum logic {
        ST_EVEN = 1'b0,
        ST_ODD  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        BAYER_G1 = 2'd0,
        BAYER_R  = 2'd1,
        BAYER_B  = 2'd2,
        BAYER_G2 = 2'd3
    } bayer_e;

    // GRBG: even rows G,R ; odd rows B,G
    function automatic bayer_e bayer_color(input logic y0, input logic x0);
        bayer_e c;
        case ({y0, x0})
            2'b00:   c = BAYER_G1;
            2'b01:   c = BAYER_R;
            2'b10:   c = BAYER_B;
            2'b11:   c = BAYER_G2;
            default: c = BAYER_G1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rgb2raw_line_ram.sv
// -----------------------------------------------------------------------------
// rgb2raw_line_ram
// Simple dual-port synchronous RAM holding one half-width line of {G,B}.
// Read latency is one clock; read-during-write to the same address returns
// an undefined mix and is never relied upon by the re-mosaic core.
// Ports:
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe (rd_data holds when low)
//   rd_addr  : read address
//   rd_data  : registered read data
// -----------------------------------------------------------------------------
module rgb2raw_line_ram #(
    parameter int DEPTH = 640,
    parameter int AW    = 10,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array with one write port and one registered read port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/rgb2raw_mosaic.sv
// -----------------------------------------------------------------------------
// rgb2raw_mosaic
// Expands a half-resolution RGB stream into a full-resolution GRBG Bayer RAW
// stream: every accepted RGB pixel becomes one 2x2 quad. The even raw row is
// emitted directly from the input (G then R); {G,B} is parked in a line RAM
// and replayed as the odd raw row (B then G).
//
// Optional build macro RGB2RAW_STATS_EN adds oERR (sticky protocol error)
// and oFRAME_CNT (completed frame counter).
//
// Ports:
//   iCLK, iRST            : clock, synchronous active-high reset
//   iSOF                  : start-of-frame, restarts at raw (0,0)
//   iRed/iGreen/iBlue     : input pixel, DW bits each
//   iDVAL / oREADY        : input handshake (transfer = iDVAL & oREADY)
//   oDATA/oDVAL           : RAW sample and valid
//   oX_Cont/oY_Cont       : raw column/row of oDATA
//   oSOF                  : marks sample (0,0)
//   oERR, oFRAME_CNT      : statistics (RGB2RAW_STATS_EN only)
// -----------------------------------------------------------------------------
module rgb2raw_mosaic
    import rgb2raw_pkg::*;
#(
    parameter int IMG_WIDTH  = 1280,
    parameter int IMG_HEIGHT = 1024,
    parameter int DW         = RGB2RAW_DW
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iSOF,
    input  logic [DW-1:0]    iRed,
    input  logic [DW-1:0]    iGreen,
    input  logic [DW-1:0]    iBlue,
    input  logic             iDVAL,
    output logic             oREADY,
    output logic [DW-1:0]    oDATA,
    output logic             oDVAL,
    output logic [CNT_W-1:0] oX_Cont,
    output logic [CNT_W-1:0] oY_Cont,
    output logic             oSOF
`ifdef RGB2RAW_STATS_EN
    ,
    output logic             oERR,
    output logic [15:0]      oFRAME_CNT
`endif
);

    localparam int RAM_DEPTH = IMG_WIDTH / 2;
    localparam int RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    localparam logic [CNT_W-1:0]  X_LAST   = CNT_W'(IMG_WIDTH - 1);
    localparam logic [CNT_W-1:0]  Y_LAST   = CNT_W'(IMG_HEIGHT - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [RAM_AW-1:0] ADDR_ONE = RAM_AW'(1);

    // Control state
    state_e            state_q, state_d;
    logic              p_q, p_d;
    logic [CNT_W-1:0]  x_q, x_d;
    logic [CNT_W-1:0]  y_q, y_d;
    logic [DW-1:0]     red_q, red_d;

    // Registered outputs
    logic [DW-1:0]     odata_q, odata_d;
    logic              odval_q, odval_d;
    logic [CNT_W-1:0]  ox_q, ox_d;
    logic [CNT_W-1:0]  oy_q, oy_d;
    logic              osof_q, osof_d;

    // Per-cycle decisions
    logic              ready_s;
    logic              emit_s;
    logic [CNT_W-1:0]  emit_x_s;
    logic [CNT_W-1:0]  emit_y_s;
    bayer_e            color_s;
    logic [DW-1:0]     sample_s;

    // Line RAM
    logic              wr_en_s;
    logic [RAM_AW-1:0] wr_addr_s;
    logic [2*DW-1:0]   wr_data_s;
    logic              rd_en_s;
    logic [RAM_AW-1:0] rd_addr_s;
    logic [2*DW-1:0]   rd_data_s;

    // iSOF forces acceptance so a pixel presented with it becomes pixel (0,0)
    assign ready_s = iSOF | ((state_q == ST_EVEN) & ~p_q);
    assign oREADY  = ready_s;

    rgb2raw_line_ram #(
        .DEPTH (RAM_DEPTH),
        .AW    (RAM_AW),
        .WIDTH (2 * DW)
    ) u_line_ram (
        .clk     (iCLK),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_s),
        .wr_data (wr_data_s),
        .rd_en   (rd_en_s),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    // Next-state logic: decides which raw sample (if any) is produced this cycle
    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        x_d       = x_q;
        y_d       = y_q;
        red_d     = red_q;
        emit_s    = 1'b0;
        emit_x_s  = x_q;
        emit_y_s  = y_q;
        wr_en_s   = 1'b0;
        wr_addr_s = x_q[RAM_AW:1];
        wr_data_s = {iGreen, iBlue};
        rd_en_s   = 1'b0;
        rd_addr_s = x_q[RAM_AW:1] + ADDR_ONE;

        if (iSOF) begin
            // Restart drops any pending R or odd-row replay
            state_d  = ST_EVEN;
            p_d      = 1'b0;
            x_d      = CNT_ZERO;
            y_d      = CNT_ZERO;
            emit_x_s = CNT_ZERO;
            emit_y_s = CNT_ZERO;
            if (iDVAL) begin
                wr_en_s   = 1'b1;
                wr_addr_s = {RAM_AW{1'b0}};
                red_d     = iRed;
                emit_s    = 1'b1;
                x_d       = CNT_ONE;
                p_d       = 1'b1;
            end else begin
                red_d = red_q;
            end
        end else begin
            case (state_q)
                ST_EVEN: begin
                    if (!p_q) begin
                        if (iDVAL) begin
                            // G goes out now, R is held for the next cycle
                            wr_en_s = 1'b1;
                            red_d   = iRed;
                            emit_s  = 1'b1;
                            x_d     = x_q + CNT_ONE;
                            p_d     = 1'b1;
                        end else begin
                            x_d = x_q;
                        end
                    end else begin
                        emit_s = 1'b1;
                        p_d    = 1'b0;
                        if (x_q == X_LAST) begin
                            // Prefetch quad 0 so the odd row starts without a bubble
                            state_d   = ST_ODD;
                            x_d       = CNT_ZERO;
                            y_d       = y_q + CNT_ONE;
                            rd_en_s   = 1'b1;
                            rd_addr_s = {RAM_AW{1'b0}};
                        end else begin
                            x_d = x_q + CNT_ONE;
                        end
                    end
                end
                ST_ODD: begin
                    emit_s = 1'b1;
                    if (!p_q) begin
                        x_d = x_q + CNT_ONE;
                        p_d = 1'b1;
                    end else begin
                        p_d = 1'b0;
                        if (x_q == X_LAST) begin
                            state_d = ST_EVEN;
                            x_d     = CNT_ZERO;
                            if (y_q == Y_LAST) begin
                                y_d = CNT_ZERO;
                            end else begin
                                y_d = y_q + CNT_ONE;
                            end
                        end else begin
                            // Fetch the next quad while its G is still being emitted
                            x_d     = x_q + CNT_ONE;
                            rd_en_s = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_EVEN;
                    p_d     = 1'b0;
                    x_d     = CNT_ZERO;
                end
            endcase
        end
    end

    // Sample mux: the colour at the emitted position selects the source
    always_comb begin
        color_s = bayer_color(emit_y_s[0], emit_x_s[0]);
        case (color_s)
            BAYER_G1: sample_s = iGreen;
            BAYER_R:  sample_s = red_q;
            BAYER_B:  sample_s = rd_data_s[DW-1:0];
            BAYER_G2: sample_s = rd_data_s[2*DW-1:DW];
            default:  sample_s = {DW{1'b0}};
        endcase
    end

    // Output register inputs; data and coordinates hold between samples
    always_comb begin
        odval_d = emit_s;
        if (emit_s) begin
            odata_d = sample_s;
            ox_d    = emit_x_s;
            oy_d    = emit_y_s;
        end else begin
            odata_d = odata_q;
            ox_d    = ox_q;
            oy_d    = oy_q;
        end
        osof_d = emit_s & (emit_x_s == CNT_ZERO) & (emit_y_s == CNT_ZERO);
    end

    // State and output registers
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= ST_EVEN;
            p_q     <= 1'b0;
            x_q     <= CNT_ZERO;
            y_q     <= CNT_ZERO;
            red_q   <= {DW{1'b0}};
            odata_q <= {DW{1'b0}};
            odval_q <= 1'b0;
            ox_q    <= CNT_ZERO;
            oy_q    <= CNT_ZERO;
            osof_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            x_q     <= x_d;
            y_q     <= y_d;
            red_q   <= red_d;
            odata_q <= odata_d;
            odval_q <= odval_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            osof_q  <= osof_d;
        end
    end

    assign oDATA   = odata_q;
    assign oDVAL   = odval_q;
    assign oX_Cont = ox_q;
    assign oY_Cont = oy_q;
    assign oSOF    = osof_q;

`ifdef RGB2RAW_STATS_EN
    logic        err_q, err_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        frame_end_s;

    // Statistics next-state: sticky error and completed-frame count
    always_comb begin
        frame_end_s = emit_s & ~iSOF & (state_q == ST_ODD) & p_q
                    & (x_q == X_LAST) & (y_q == Y_LAST);
        if (iSOF) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q | (iDVAL & ~ready_s);
        end
        if (frame_end_s) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Statistics registers; the frame count survives iSOF
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            err_q       <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign oERR       = err_q;
    assign oFRAME_CNT = frame_cnt_q;
`endif

endmodule

// File: tb/tb_rgb2raw_mosaic.sv
// -----------------------------------------------------------------------------
// tb_rgb2raw_mosaic
// Directed self-checking bench for rgb2raw_mosaic with an 8x4 raw frame.
// Expected RAW samples are derived from the GRBG rule: even row G,R of each
// input pixel, odd row B,G of the same pixel.
// -----------------------------------------------------------------------------
module tb_rgb2raw_mosaic;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          sof;
    logic          dval;
    logic [DW-1:0] red;
    logic [DW-1:0] green;
    logic [DW-1:0] blue;
    logic          ready;
    logic [DW-1:0] odata;
    logic          odval;
    logic [10:0]   ox;
    logic [10:0]   oy;
    logic          osof;
`ifdef RGB2RAW_STATS_EN
    logic          oerr;
    logic [15:0]   fcnt;
`endif

    always #5 clk = ~clk;

    rgb2raw_mosaic #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .DW         (DW)
    ) dut (
        .iCLK    (clk),
        .iRST    (rst),
        .iSOF    (sof),
        .iRed    (red),
        .iGreen  (green),
        .iBlue   (blue),
        .iDVAL   (dval),
        .oREADY  (ready),
        .oDATA   (odata),
        .oDVAL   (odval),
        .oX_Cont (ox),
        .oY_Cont (oy),
        .oSOF    (osof)
`ifdef RGB2RAW_STATS_EN
        ,
        .oERR       (oerr),
        .oFRAME_CNT (fcnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        logic [31:0] key;   // {y[10:0], x[10:0], data[9:0]}
        logic        sof;
        logic        rdy;
    } samp_t;

    samp_t sq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every valid RAW sample mid-cycle
    always @(negedge clk) begin
        if (odval === 1'b1) begin
            sq.push_back('{cyc, {oy, ox, odata}, osof, ready});
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got time %0t required < 200000", $time);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one pixel and hold it until accepted
    task automatic push_pixel(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                              input bit hold);
        int gd = 0;
        red   = r;
        green = g;
        blue  = b;
        if (!hold) dval = 1'b0;
        while (ready !== 1'b1 && gd < 100) begin
            tick();
            gd++;
        end
        chk("ready_wait", {31'd0, ready}, 32'd1);
        dval = 1'b1;
        tick();
        if (!hold) dval = 1'b0;
    endtask

    task automatic wait_samples(input int n);
        int gd = 0;
        while (sq.size() < n && gd < 300) begin
            tick();
            gd++;
        end
        chk("sample_count", sq.size(), n);
    endtask

    // Compare one raw row in the capture queue against the GRBG expectation
    task automatic check_row(input int base, input int y, input int ib, input bit odd,
                             input int gap_diff, input string tag);
        for (int k = 0; k < W; k++) begin
            logic [9:0]  d;
            logic [31:0] e;
            if (!odd) d = ((k % 2) == 0) ? 10'h200 : 10'h100;
            else      d = ((k % 2) == 0) ? 10'h300 : 10'h200;
            d = d + 10'(ib + k / 2);
            e = {11'(y), 11'(k), d};
            if (base + k < sq.size()) chk(tag, sq[base + k].key, e);
            else                      chk({tag, "_missing"}, 32'(sq.size()), 32'(base + k + 1));
            if (k > 0 && base + k < sq.size())
                chk({tag, "_spacing"}, 32'(sq[base + k].cyc - sq[base + k - 1].cyc),
                    ((k % 2) == 1) ? 32'd1 : 32'(gap_diff));
        end
    endtask

    initial begin
        int nz;
        int cnt;
        int base;
        int gd;

        rst = 1'b1; sof = 1'b0; dval = 1'b0;
        red = 10'd0; green = 10'd0; blue = 10'd0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Reset / idle state
        chk("rst_dval",  {31'd0, odval}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_data",  32'(odata), 32'd0);
        chk("rst_x",     32'(ox), 32'd0);
        chk("rst_y",     32'(oy), 32'd0);
        chk("rst_sof",   {31'd0, osof}, 32'd0);
        chk("rst_quiet", sq.size(), 32'd0);

        // Rows 0/1: iDVAL held high, gapless
        for (int i = 0; i < 4; i++)
            push_pixel(10'(16'h100 + i), 10'(16'h200 + i), 10'(16'h300 + i), 1'b1);
        dval = 1'b0;
        wait_samples(16);
        check_row(0, 0, 0, 1'b0, 1, "r0_even");
        check_row(8, 1, 0, 1'b1, 1, "r1_odd");
        nz = 0;
        for (int k = 0; k < W - 1; k++) if (sq[8 + k].rdy !== 1'b0) nz++;
        chk("r1_ready_low", nz, 32'd0);

        // Rows 2/3: 1-on / 3-off input, gaps on even row only
        for (int i = 0; i < 4; i++) begin
            push_pixel(10'(16'h104 + i), 10'(16'h204 + i), 10'(16'h304 + i), 1'b0);
            repeat (3) tick();
        end
        wait_samples(32);
        check_row(16, 2, 4, 1'b0, 3, "r2_even_gapped");
        check_row(24, 3, 4, 1'b1, 1, "r3_odd");

        // Whole frame: single oSOF at the first sample, nothing after the wrap
        cnt = 0;
        for (int k = 0; k < 32; k++) if (sq[k].sof === 1'b1) cnt++;
        chk("f1_sof_count", cnt, 32'd1);
        chk("f1_sof_first", {31'd0, sq[0].sof}, 32'd1);
        repeat (4) tick();
        chk("f1_idle_after", sq.size(), 32'd32);
`ifdef RGB2RAW_STATS_EN
        chk("f1_frame_cnt", 32'(fcnt), 32'd1);
        chk("f1_err_sticky", {31'd0, oerr}, 32'd1);
`endif

        // Frame 2 starts without iSOF, then iSOF lands mid odd row at X=4
        for (int i = 0; i < 4; i++)
            push_pixel(10'(16'h100 + i), 10'(16'h200 + i), 10'(16'h300 + i), 1'b0);
        chk("f2_start_y", sq[32].key, {11'd0, 11'd0, 10'h200});
        chk("f2_start_sof", {31'd0, sq[32].sof}, 32'd1);
        gd = 0;
        while (!(odval === 1'b1 && oy == 11'd1 && ox == 11'd3) && gd < 100) begin
            tick();
            gd++;
        end
        chk("f2_reach_x3", {oy, ox, 10'd0}, {11'd1, 11'd3, 10'd0});
        sof = 1'b1;
        tick();
        sof = 1'b0;
        chk("sof_dval_low", {31'd0, odval}, 32'd0);
        chk("sof_ready", {31'd0, ready}, 32'd1);
        base = sq.size();
        chk("sof_partial_rows", base - 32, 32'd12);
`ifdef RGB2RAW_STATS_EN
        chk("sof_err_cleared", {31'd0, oerr}, 32'd0);
`endif
        repeat (3) tick();
        chk("sof_no_stale", sq.size(), base);

        // First transfer after iSOF is raw (0,0)
        push_pixel(10'h1AA, 10'h2BB, 10'h3CC, 1'b0);
        wait_samples(base + 2);
        chk("sof_g00", sq[base].key, {11'd0, 11'd0, 10'h2BB});
        chk("sof_g00_flag", {31'd0, sq[base].sof}, 32'd1);
        chk("sof_r01", sq[base + 1].key, {11'd0, 11'd1, 10'h1AA});
        chk("sof_r01_flag", {31'd0, sq[base + 1].sof}, 32'd0);
        for (int i = 1; i < 8; i++)
            push_pixel(10'(16'h110 + i), 10'(16'h210 + i), 10'(16'h310 + i), 1'b0);
        wait_samples(base + 32);
        chk("f3_b10", sq[base + 8].key, {11'd1, 11'd0, 10'h3CC});
        chk("f3_g11", sq[base + 9].key, {11'd1, 11'd1, 10'h2BB});
        chk("f3_last", sq[base + 31].key, {11'd3, 11'd7, 10'h217});
`ifdef RGB2RAW_STATS_EN
        chk("f3_frame_cnt", 32'(fcnt), 32'd2);
        chk("f3_err_clean", {31'd0, oerr}, 32'd0);
`endif

        // iDVAL during the odd row is ignored by the core
        base = sq.size();
        for (int i = 0; i < 4; i++)
            push_pixel(10'(16'h120 + i), 10'(16'h220 + i), 10'(16'h320 + i), 1'b0);
        gd = 0;
        while (!(odval === 1'b1 && oy == 11'd1 && ox == 11'd1) && gd < 100) begin
            tick();
            gd++;
        end
        red = 10'h3FF; green = 10'h3FF; blue = 10'h3FF;
        dval = 1'b1;
        tick();
        dval = 1'b0;
`ifdef RGB2RAW_STATS_EN
        chk("odd_dval_err", {31'd0, oerr}, 32'd1);
        repeat (5) tick();
        chk("odd_err_holds", {31'd0, oerr}, 32'd1);
`endif
        wait_samples(base + 16);
        chk("f4_sof_nosof_wrap", {31'd0, sq[base].sof}, 32'd1);
        check_row(base, 0, 32, 1'b0, 1, "f4_even");
        check_row(base + 8, 1, 32, 1'b1, 1, "f4_odd_ignored_dval");
        sof = 1'b1;
        tick();
        sof = 1'b0;
`ifdef RGB2RAW_STATS_EN
        chk("f4_err_cleared", {31'd0, oerr}, 32'd0);
        chk("f4_cnt_kept", 32'(fcnt), 32'd2);
`endif
        chk("f4_sof_dval_low", {31'd0, odval}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
